// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       mr;
        logic [4:0] dest;
    } entry_t;

    localparam entry_t BUBBLE = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, dest: 5'd0};

    // Register 0 is hardwired, so an entry targeting it never produces a value.
    function automatic logic writes_reg(input entry_t e);
        return e.valid && e.rw && (e.dest != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Operand forward select for one ALU source, from the entries about to
// occupy MEM (current ex_e) and WB (current mem_e).
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       uses,
    input  entry_t     ex_e,
    input  entry_t     mem_e,
    output logic [1:0] sel
);

    always_comb begin
        // NOTE: default assigned first so every path drives sel and no latch is inferred.
        sel = FWD_RF;
        if (uses) begin
            if (writes_reg(ex_e) && ex_e.dest == src) begin
                sel = FWD_MEM;
            end else if (writes_reg(mem_e) && mem_e.dest == src) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection, stall/flush generation and registered forwarding selects
// for the five-stage core, with a saturating load-use stall counter.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_aw,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    entry_t     ex_e, mem_e, wb_e, id_e;
    logic       load_use;
    logic       bubble;
    logic [1:0] sel_a, sel_b;
    logic       unused_wb;

    assign load_use = id_valid && ex_e.valid && ex_e.mr && (ex_e.dest != 5'd0) &&
                      ((id_uses_rs && id_rs == ex_e.dest) ||
                       (id_uses_rt && id_rt == ex_e.dest));

    // A taken branch kills the consumer anyway, so it wins over a load-use stall.
    assign flush  = ex_branch_taken;
    assign stall  = mem_busy || (load_use && !ex_branch_taken);
    assign bubble = stall || flush || !id_valid;

    assign id_e = '{valid: 1'b1, rw: id_reg_write, mr: id_mem_read, dest: id_aw};

    // WB is shadowed for completeness; write-before-read in the register file
    // means it never needs a forwarding path.
    assign unused_wb = ^wb_e;

    fwd_select u_fwd_a (
        .src   (id_rs),
        .uses  (id_uses_rs),
        .ex_e  (ex_e),
        .mem_e (mem_e),
        .sel   (sel_a)
    );

    fwd_select u_fwd_b (
        .src   (id_rt),
        .uses  (id_uses_rt),
        .ex_e  (ex_e),
        .mem_e (mem_e),
        .sel   (sel_b)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so each stage shifts from its pre-edge neighbour.
        if (!rst_n) begin
            ex_e      <= BUBBLE;
            mem_e     <= BUBBLE;
            wb_e      <= BUBBLE;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
        end else if (!mem_busy) begin
            wb_e  <= mem_e;
            mem_e <= ex_e;
            ex_e  <= bubble ? BUBBLE : id_e;
            fwd_a <= bubble ? FWD_RF : sel_a;
            fwd_b <= bubble ? FWD_RF : sel_b;
            if (load_use && !flush && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the five-stage MIPS core. It watches the instruction leaving ID and shadows the destination register of every instruction in EX, MEM and WB. From that it drives stall/flush to the front end, and the registered forwarding selects that steer the ALU operand muxes ahead of the rt/imm source select. It also keeps a saturating count of load-use stalls.

## Interface
- CNT_W, 16, width of load-use stall counter
- clk  in  1  core clock
- rst_n  in  1  reset, active-low, synchronous (one clock, all state on rising edge of clk)
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers in ID
- id_uses_rs, id_uses_rt  in  1 each  instruction reads that source
- id_aw  in  5  destination chosen by the rt/rd mux
- id_reg_write  in  1  instruction writes id_aw
- id_mem_read  in  1  instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_busy  in  1  data memory not ready; whole pipe freezes
- stall  out  1  hold PC and IF/ID; inject bubble into EX
- flush  out  1  kill IF/ID contents
- fwd_a, fwd_b  out  2 each  EX operand source: 00 register file, 01 MEM-stage result, 10 WB-stage result
- stall_cnt  out  CNT_W  load-use stalls taken, saturating

## Operation
- Tracker: three entries ex_e, mem_e, wb_e. Each is {valid, rw, mr, dest[4:0]}. An entry writes only if valid && rw && dest != 0. Register 0 never hazards and never forwards.
- load_use = ex_e.valid && ex_e.mr && ex_e.dest != 0 && ((id_uses_rs && id_rs == ex_e.dest) || (id_uses_rt && id_rt == ex_e.dest)), gated by id_valid.
- flush = ex_branch_taken. stall = mem_busy || (load_use && !ex_branch_taken). Flush overrides load-use stall.
- Advance, when !mem_busy: wb_e <= mem_e; mem_e <= ex_e. ex_e <= bubble (valid 0) if stall or flush or !id_valid; otherwise ex_e <= ID fields.
- Forward select per operand, evaluated from ID fields, registered with ex_e:
  - if ex_e writes and equals the source, select 01;
  - else if mem_e writes and equals the source, select 10;
  - else select 00. The register file writes before it reads in the same cycle, so the WB entry needs no forwarding.
- Selects are forced to 00 when the source is unused or the EX slot gets a bubble.
- stall_cnt increments by 1 on each advancing cycle with load_use && !flush. It holds at all-ones.
- mem_busy freeze: tracker, fwd_a/b and stall_cnt hold. stall=1. flush still follows ex_branch_taken, and the front end ignores it until release.

## Timing
- Reset (rst_n low at an edge): all entries invalid, fwd_a=fwd_b=00, stall_cnt=0. stall and flush are combinational and read 0 once inputs are idle.
- stall/flush: same-cycle combinational from ID/EX state, 0-cycle latency.
- fwd_a/fwd_b: one-cycle latency. Valid during the cycle the instruction occupies EX.
- Load-use costs exactly one bubble. The next cycle the load sits in mem_e, and the consumer gets select 10.
- Simultaneous flush and load_use: flush only, no stall, no count.
- Reset asserted mid-stall or mid-freeze: it clears everything at that edge regardless of mem_busy.

## Structure
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - the tracker entry struct;
  - the bubble constant.
- One sub-module, fwd_select (combinational). Inputs: src, uses, ex_e, mem_e. Output: 2-bit select. Instantiated once for rs and once for rt.

## Test plan
- add $3,$1,$2 then sub $4,$3,$5 back-to-back -> no stall, fwd_a=01 while sub in EX.
- add $3 then nop then or $6,$7,$3 -> fwd_b=10 for or. With $0 as destination instead, fwd stays 00.
- lw $8 then add $9,$8,$8 -> stall=1 one cycle, bubble in EX, then fwd_a=fwd_b=10, stall_cnt 0→1.
- lw $8 followed by dependent add while ex_branch_taken=1 -> flush=1, stall=0, stall_cnt unchanged.
- mem_busy high 3 cycles during dependent sequence -> stall=1 throughout, fwd and tracker frozen, correct forwarding on release.
- Preload stall_cnt path to all-ones via 2^CNT_W stalls (CNT_W=4 build) -> stays 15. rst_n low mid-sequence -> all outputs to reset values next edge.
